// File: rtl/s2mm_desc_pkg.sv
// s2mm_desc_pkg: shared types and helpers for the S2MM descriptor scheduler.
// The optional watchdog is enabled with S2MM_DESC_TIMEOUT_EN.
package s2mm_desc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4
  } s2mm_desc_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] len;
    logic [3:0]  tag;
  } s2mm_desc_t;

  localparam logic [31:0] S2MM_MAX_CHUNK_DFLT = 32'h0080_0000;

  function automatic logic [31:0] chunk_of(
    input logic [31:0] rem,
    input logic [31:0] lim
  );
    return (rem > lim) ? lim : rem;
  endfunction

endpackage

// File: rtl/s2mm_desc_fifo.sv
// s2mm_desc_fifo: synchronous descriptor FIFO with registered flags.
// Part of s2mm_desc_sched (watchdog macro S2MM_DESC_TIMEOUT_EN lives in the top).
module s2mm_desc_fifo
  import s2mm_desc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  s2mm_desc_t               i_data,
  input  logic                     i_pop,
  output s2mm_desc_t               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  s2mm_desc_t          r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_full;
  logic                r_empty;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_count_nxt;

  assign w_push      = i_push && !r_full;
  assign w_pop       = i_pop && !r_empty;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/s2mm_desc_sched.sv
// s2mm_desc_sched: buffers write descriptors, splits and issues chunks.
// Define S2MM_DESC_TIMEOUT_EN to enable the WAIT-state watchdog.
module s2mm_desc_sched
  import s2mm_desc_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter logic [31:0] MAX_CHUNK      = S2MM_MAX_CHUNK_DFLT,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [63:0] desc_addr,
  input  logic [31:0] desc_len,
  input  logic [3:0]  desc_tag,
  output logic [63:0] dest_addr,
  output logic [31:0] byte_num,
  output logic        start,
  input  logic        s2mm_introut,
  output logic        busy,
  output logic        done_valid,
  output logic [3:0]  done_tag,
  output logic        done_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (MAX_CHUNK == 32'd0 || TIMEOUT_CYCLES == 32'd0 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("s2mm_desc_sched: illegal parameter set");
  end

  s2mm_desc_state_t r_state;
  s2mm_desc_state_t w_state_nxt;

  logic [63:0] r_cur_addr;
  logic [31:0] r_remaining;
  logic [31:0] r_chunk;
  logic [3:0]  r_cur_tag;
  logic        r_irq_q;
  logic        r_start;
  logic [63:0] r_dest_addr;
  logic [31:0] r_byte_num;
  logic        r_busy;
  logic        r_done_valid;
  logic [3:0]  r_done_tag;
  logic        r_done_err;

  s2mm_desc_t  w_din;
  s2mm_desc_t  w_head;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_irq_rise;
  logic        w_last;
  logic        w_expire;
  logic [63:0] w_nxt_addr;
  logic [31:0] w_nxt_rem;
  logic [31:0] w_load_chunk;
  logic [31:0] w_next_chunk;

  assign w_din  = '{addr: desc_addr, len: desc_len, tag: desc_tag};
  assign w_push = desc_valid && desc_ready;
  assign w_pop  = (r_state == ST_LOAD);

  s2mm_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_din),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_count_nxt  = w_count + CW'(w_push) - CW'(w_pop);
  assign w_irq_rise   = s2mm_introut && !r_irq_q;
  assign w_last       = (r_remaining == r_chunk);
  assign w_nxt_addr   = r_cur_addr + {32'd0, r_chunk};
  assign w_nxt_rem    = r_remaining - r_chunk;
  assign w_load_chunk = chunk_of(w_head.len, MAX_CHUNK);
  assign w_next_chunk = chunk_of(w_nxt_rem, MAX_CHUNK);

`ifdef S2MM_DESC_TIMEOUT_EN
  logic [31:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign w_expire = (r_state == ST_WAIT) &&
                    (r_wait_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = (w_head.len == '0) ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_irq_rise)    w_state_nxt = ST_NEXT;
        else if (w_expire) w_state_nxt = ST_IDLE;
      end
      ST_NEXT:  w_state_nxt = (w_nxt_rem == '0) ? ST_IDLE : ST_ISSUE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered one state early so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_chunk      <= '0;
      r_cur_tag    <= '0;
      r_irq_q      <= 1'b0;
      r_start      <= 1'b0;
      r_dest_addr  <= '0;
      r_byte_num   <= '0;
      r_busy       <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_tag   <= '0;
      r_done_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_irq_q      <= s2mm_introut;
      r_start      <= 1'b0;
      r_done_valid <= 1'b0;
      r_busy       <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty && w_head.len == '0) begin
            r_done_valid <= 1'b1;
            r_done_tag   <= w_head.tag;
            r_done_err   <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_cur_addr  <= w_head.addr;
          r_remaining <= w_head.len;
          r_cur_tag   <= w_head.tag;
          if (w_head.len != '0) begin
            r_chunk     <= w_load_chunk;
            r_start     <= 1'b1;
            r_dest_addr <= w_head.addr;
            r_byte_num  <= w_load_chunk;
          end
        end
        ST_WAIT: begin
          if (w_irq_rise) begin
            if (w_last) begin
              r_done_valid <= 1'b1;
              r_done_tag   <= r_cur_tag;
              r_done_err   <= 1'b0;
            end
          end else if (w_expire) begin
            r_done_valid <= 1'b1;
            r_done_tag   <= r_cur_tag;
            r_done_err   <= 1'b1;
          end
        end
        ST_NEXT: begin
          r_cur_addr  <= w_nxt_addr;
          r_remaining <= w_nxt_rem;
          if (w_nxt_rem != '0) begin
            r_chunk     <= w_next_chunk;
            r_start     <= 1'b1;
            r_dest_addr <= w_nxt_addr;
            r_byte_num  <= w_next_chunk;
          end
        end
        default: ;
      endcase
    end
  end

  assign desc_ready = !w_full;
  assign dest_addr  = r_dest_addr;
  assign byte_num   = r_byte_num;
  assign start      = r_start;
  assign busy       = r_busy;
  assign done_valid = r_done_valid;
  assign done_tag   = r_done_tag;
  assign done_err   = r_done_err;

endmodule

// File: tb/tb_s2mm_desc_sched.sv
// tb_s2mm_desc_sched: directed and randomized checks for s2mm_desc_sched.
// Build with S2MM_DESC_TIMEOUT_EN to also exercise the watchdog.
module tb_s2mm_desc_sched;

  localparam logic [31:0] MAXC  = 32'h100;
  localparam logic [31:0] TMO   = 32'd40;
  localparam int          NDESC = 40;

  typedef struct {
    logic [63:0] a;
    logic [31:0] l;
  } chunk_t;

  logic        clk;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_addr;
  logic [31:0] desc_len;
  logic [3:0]  desc_tag;
  logic [63:0] dest_addr;
  logic [31:0] byte_num;
  logic        start;
  logic        s2mm_introut;
  logic        busy;
  logic        done_valid;
  logic [3:0]  done_tag;
  logic        done_err;

  int checks   = 0;
  int failures = 0;

  s2mm_desc_sched #(
    .DEPTH          (8),
    .MAX_CHUNK      (MAXC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_addr    (desc_addr),
    .desc_len     (desc_len),
    .desc_tag     (desc_tag),
    .dest_addr    (dest_addr),
    .byte_num     (byte_num),
    .start        (start),
    .s2mm_introut (s2mm_introut),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_tag     (done_tag),
    .done_err     (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: called on a falling edge, return on a falling edge.
  task automatic push(input logic [63:0] a, input logic [31:0] l,
                      input logic [3:0] t);
    int k;
    k = 0;
    while (!desc_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!desc_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout desc_ready=%0b required=1", desc_ready);
    end else begin
      desc_valid = 1'b1;
      desc_addr  = a;
      desc_len   = l;
      desc_tag   = t;
      @(negedge clk);
      desc_valid = 1'b0;
    end
  endtask

  task automatic pulse_irq();
    s2mm_introut = 1'b1;
    @(negedge clk);
    s2mm_introut = 1'b0;
  endtask

  task automatic wait_start(input int lim, output bit got);
    int i;
    got = 1'b0;
    i = 0;
    while (!start && i < lim) begin
      @(negedge clk);
      i++;
    end
    got = start;
  endtask

  task automatic test_reset();
    checks++;
    if ({desc_ready, start, busy, done_valid, done_err} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=10000",
               {desc_ready, start, busy, done_valid, done_err});
    end
    checks++;
    if (dest_addr !== 64'd0 || byte_num !== 32'd0 || done_tag !== 4'd0) begin
      failures++;
      $display("FAIL reset_data dest=%h byte=%h tag=%h required=0",
               dest_addr, byte_num, done_tag);
    end
  endtask

  task automatic test_single();
    pulse_irq();
    repeat (2) @(negedge clk);
    checks++;
    if (start !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL spurious_irq start=%0b done=%0b busy=%0b required=0",
               start, done_valid, busy);
    end
    push(64'h1_0000_1000, 32'h0C0, 4'd3);
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL single_n1 start=%0b required=0", start);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL single_n2 start=%0b required=0", start);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || dest_addr !== 64'h1_0000_1000 ||
        byte_num !== 32'h0C0) begin
      failures++;
      $display("FAIL single_n3 start=%0b dest=%h byte=%h required 1/%h/%h",
               start, dest_addr, byte_num, 64'h1_0000_1000, 32'h0C0);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse start=%0b required=0", start);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dest_addr !== 64'h1_0000_1000 || byte_num !== 32'h0C0 ||
        done_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_hold dest=%h byte=%h done=%0b", dest_addr,
               byte_num, done_valid);
    end
    pulse_irq();
    checks++;
    if (done_valid !== 1'b1 || done_tag !== 4'd3 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL single_done v=%0b tag=%0d err=%0b required 1/3/0",
               done_valid, done_tag, done_err);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_after done=%0b busy=%0b required=0",
               done_valid, busy);
    end
  endtask

  task automatic test_split();
    logic [63:0] a;
    logic [31:0] rem;
    logic [31:0] c;
    bit          got;
    a   = 64'd0;
    rem = 32'h250;
    push(64'd0, 32'h250, 4'd5);
    while (rem != 0) begin
      c = (rem > MAXC) ? MAXC : rem;
      wait_start(10, got);
      checks++;
      if (!got || dest_addr !== a || byte_num !== c) begin
        failures++;
        $display("FAIL split_chunk start=%0b dest=%h byte=%h required %h/%h",
                 got, dest_addr, byte_num, a, c);
      end
      repeat (2) @(negedge clk);
      pulse_irq();
      a   = a + 64'(c);
      rem = rem - c;
      if (rem == 0) begin
        checks++;
        if (done_valid !== 1'b1 || done_tag !== 4'd5 || done_err !== 1'b0) begin
          failures++;
          $display("FAIL split_done v=%0b tag=%0d err=%0b required 1/5/0",
                   done_valid, done_tag, done_err);
        end
      end else begin
        checks++;
        if (done_valid !== 1'b0) begin
          failures++;
          $display("FAIL split_early_done v=%0b required=0", done_valid);
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b1) begin
          failures++;
          $display("FAIL split_reissue start=%0b required=1", start);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done_valid !== 1'b0) begin
      failures++;
      $display("FAIL split_single_done v=%0b required=0", done_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    push(64'h2000, 32'h40, 4'd1);
    push(64'h3000, 32'h40, 4'd2);
    wait_start(10, got);
    checks++;
    if (!got || dest_addr !== 64'h2000) begin
      failures++;
      $display("FAIL b2b_first start=%0b dest=%h required 1/2000", got,
               dest_addr);
    end
    @(negedge clk);
    pulse_irq();
    checks++;
    if (done_valid !== 1'b1 || done_tag !== 4'd1) begin
      failures++;
      $display("FAIL b2b_done1 v=%0b tag=%0d required 1/1", done_valid,
               done_tag);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early start=%0b required=0", start);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || dest_addr !== 64'h3000) begin
      failures++;
      $display("FAIL b2b_second start=%0b dest=%h required 1/3000", start,
               dest_addr);
    end
    @(negedge clk);
    pulse_irq();
    checks++;
    if (done_valid !== 1'b1 || done_tag !== 4'd2) begin
      failures++;
      $display("FAIL b2b_done2 v=%0b tag=%0d required 1/2", done_valid,
               done_tag);
    end
  endtask

  task automatic test_zero_len();
    bit       saw_start;
    bit       saw_done;
    logic [3:0] t;
    logic     e;
    saw_start = 1'b0;
    saw_done  = 1'b0;
    t = 4'd0;
    e = 1'b0;
    push(64'h55, 32'd0, 4'd7);
    for (int i = 0; i < 6; i++) begin
      if (start) saw_start = 1'b1;
      if (done_valid) begin
        saw_done = 1'b1;
        t = done_tag;
        e = done_err;
      end
      @(negedge clk);
    end
    checks++;
    if (saw_start || !saw_done || t !== 4'd7 || e !== 1'b1) begin
      failures++;
      $display("FAIL zero_len start=%0b done=%0b tag=%0d err=%0b req 0/1/7/1",
               saw_start, saw_done, t, e);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_busy busy=%0b required=0", busy);
    end
  endtask

  task automatic test_fifo_full();
    bit got;
    push(64'h4000, 32'h10, 4'd0);
    wait_start(10, got);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (desc_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_ready_%0d ready=%0b required=1", i, desc_ready);
      end
      desc_valid = 1'b1;
      desc_addr  = 64'h5000 + 64'(i) * 64'h100;
      desc_len   = 32'h10;
      desc_tag   = 4'(i + 1);
      @(negedge clk);
    end
    desc_valid = 1'b0;
    checks++;
    if (desc_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_after8 ready=%0b required=0", desc_ready);
    end
    pulse_irq();
    checks++;
    if (done_valid !== 1'b1 || done_tag !== 4'd0) begin
      failures++;
      $display("FAIL full_done0 v=%0b tag=%0d required 1/0", done_valid,
               done_tag);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_cycle ready=%0b required=0", desc_ready);
    end
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop ready=%0b required=1", desc_ready);
    end
    for (int k = 0; k < 9; k++) begin
      wait_start(20, got);
      checks++;
      if (!got || dest_addr !== 64'h5000 + 64'(k) * 64'h100) begin
        failures++;
        $display("FAIL full_drain_%0d start=%0b dest=%h", k, got, dest_addr);
      end
      if (k == 0) push(64'h5800, 32'h10, 4'd9);
      @(negedge clk);
      pulse_irq();
      checks++;
      if (done_valid !== 1'b1 || done_tag !== 4'(k + 1)) begin
        failures++;
        $display("FAIL full_drain_done_%0d v=%0b tag=%0d required tag %0d",
                 k, done_valid, done_tag, k + 1);
      end
    end
  endtask

  task automatic test_wrap_reset();
    bit got;
    bit saw;
    push(64'hFFFF_FFFF_FFFF_FF00, 32'h200, 4'd9);
    wait_start(10, got);
    checks++;
    if (!got || dest_addr !== 64'hFFFF_FFFF_FFFF_FF00 || byte_num !== MAXC) begin
      failures++;
      $display("FAIL wrap_first start=%0b dest=%h byte=%h", got, dest_addr,
               byte_num);
    end
    @(negedge clk);
    pulse_irq();
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || dest_addr !== 64'd0 || byte_num !== MAXC) begin
      failures++;
      $display("FAIL wrap_second start=%0b dest=%h byte=%h required 1/0/100",
               start, dest_addr, byte_num);
    end
    @(negedge clk);
    push(64'h7000, 32'h10, 4'd4);
    rst = 1'b0;
    #1;
    checks++;
    if ({desc_ready, start, busy, done_valid, done_err} !== 5'b10000 ||
        dest_addr !== 64'd0 || byte_num !== 32'd0 || done_tag !== 4'd0) begin
      failures++;
      $display("FAIL midreset flags=%b dest=%h byte=%h tag=%h",
               {desc_ready, start, busy, done_valid, done_err}, dest_addr,
               byte_num, done_tag);
    end
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) pulse_irq();
      if (start || done_valid) saw = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset activity=%0b busy=%0b required 0/0", saw, busy);
    end
  endtask

  task automatic test_random();
    chunk_t      exp_chunks[$];
    logic [4:0]  exp_done[$];
    logic [63:0] d_addr [NDESC];
    logic [31:0] d_len  [NDESC];
    logic [3:0]  d_tag  [NDESC];
    logic [63:0] a;
    logic [31:0] rem;
    logic [31:0] c;
    int          r;
    for (int i = 0; i < NDESC; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      d_len[i] = 32'd0;
      else if (r < 4)  d_len[i] = $urandom_range(MAXC + 1, 4 * MAXC);
      else if (r == 4) d_len[i] = MAXC;
      else             d_len[i] = $urandom_range(1, MAXC);
      d_addr[i] = {$urandom(), $urandom()};
      if (r == 5) d_addr[i] = 64'hFFFF_FFFF_FFFF_FFF0;
      d_tag[i] = 4'($urandom_range(0, 15));
      a   = d_addr[i];
      rem = d_len[i];
      while (rem != 0) begin
        c = (rem > MAXC) ? MAXC : rem;
        exp_chunks.push_back('{a: a, l: c});
        a   = a + 64'(c);
        rem = rem - c;
      end
      exp_done.push_back({d_tag[i], d_len[i] == 32'd0});
    end
    fork
      begin : producer
        for (int i = 0; i < NDESC; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push(d_addr[i], d_len[i], d_tag[i]);
        end
      end
      begin : consumer
        int          dcount;
        int          cyc;
        int          delay;
        bit          waiting;
        logic [63:0] la;
        logic [31:0] ll;
        chunk_t      ec;
        logic [4:0]  ed;
        dcount  = 0;
        cyc     = 0;
        delay   = 0;
        waiting = 1'b0;
        la      = '0;
        ll      = '0;
        while (dcount < NDESC && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (s2mm_introut) s2mm_introut = 1'b0;
          if (done_valid) begin
            checks++;
            dcount++;
            if (exp_done.size() == 0) begin
              failures++;
              $display("FAIL rand_extra_done tag=%0d", done_tag);
            end else begin
              ed = exp_done.pop_front();
              if ({done_tag, done_err} !== ed || start) begin
                failures++;
                $display("FAIL rand_done tag=%0d err=%0b start=%0b req %0d/%0b",
                         done_tag, done_err, start, ed[4:1], ed[0]);
              end
            end
          end
          if (start) begin
            checks++;
            if (exp_chunks.size() == 0) begin
              failures++;
              $display("FAIL rand_extra_start dest=%h", dest_addr);
            end else begin
              ec = exp_chunks.pop_front();
              if (dest_addr !== ec.a || byte_num !== ec.l) begin
                failures++;
                $display("FAIL rand_chunk dest=%h byte=%h required %h/%h",
                         dest_addr, byte_num, ec.a, ec.l);
              end
            end
            la      = dest_addr;
            ll      = byte_num;
            delay   = int'($urandom_range(1, 5));
            waiting = 1'b1;
          end else if (waiting) begin
            checks++;
            if (dest_addr !== la || byte_num !== ll) begin
              failures++;
              $display("FAIL rand_hold dest=%h byte=%h required %h/%h",
                       dest_addr, byte_num, la, ll);
            end
            delay--;
            if (delay == 0) begin
              s2mm_introut = 1'b1;
              waiting      = 1'b0;
            end
          end
        end
        checks++;
        if (dcount != NDESC || exp_chunks.size() != 0) begin
          failures++;
          $display("FAIL rand_complete dones=%0d required=%0d chunks_left=%0d",
                   dcount, NDESC, exp_chunks.size());
        end
      end
    join
    s2mm_introut = 1'b0;
  endtask

`ifdef S2MM_DESC_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    int n;
    push(64'h9000, 32'h10, 4'hA);
    wait_start(10, got);
    n = 0;
    while (!done_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != int'(TMO) + 1 || done_err !== 1'b1 || done_tag !== 4'hA) begin
      failures++;
      $display("FAIL timeout cycles=%0d err=%0b tag=%0d required %0d/1/10",
               n, done_err, done_tag, int'(TMO) + 1);
    end
  endtask
`endif

  initial begin
    rst          = 1'b0;
    desc_valid   = 1'b0;
    desc_addr    = '0;
    desc_len     = '0;
    desc_tag     = '0;
    s2mm_introut = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_split();
    test_back_to_back();
    test_zero_len();
    test_fifo_full();
    test_random();
`ifdef S2MM_DESC_TIMEOUT_EN
    test_timeout();
`endif
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s2mm_desc_sched.md
# s2mm_desc_sched

Upstream command stage for the S2MM write controller. Accepts 64-bit-address write descriptors on a valid/ready port, buffers them in a small FIFO, splits each into chunks no larger than the DMA length-register limit, and issues them one at a time as a `start` pulse with stable `dest_addr`/`byte_num`. Each chunk is held until the S2MM completion interrupt arrives. When a whole descriptor finishes, the block reports completion with its tag.

## Interface
- `DEPTH`, 8: descriptor FIFO entries; power of two, ≥ 2.
- `MAX_CHUNK`, 32'h0080_0000: maximum bytes per issued chunk; must be nonzero.
- `TIMEOUT_CYCLES`, 32'd1_000_000: completion watchdog limit. Used only when `S2MM_DESC_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `desc_valid` in 1: descriptor offered.
- `desc_ready` out 1: FIFO not full.
- `desc_addr` in 64: destination byte address.
- `desc_len` in 32: byte count.
- `desc_tag` in 4: user tag, returned on completion.
- `dest_addr` out 64: chunk address to the write controller.
- `byte_num` out 32: chunk length to the write controller.
- `start` out 1: one-cycle chunk launch pulse.
- `s2mm_introut` in 1: S2MM completion interrupt; the block uses its rising edge.
- `busy` out 1: FSM not IDLE, or FIFO non-empty.
- `done_valid` out 1: one-cycle descriptor-complete pulse.
- `done_tag` out 4: tag of the completed descriptor.
- `done_err` out 1: descriptor had zero length, or timed out.

## Operation
- **Enqueue.** A descriptor is pushed on any cycle with `desc_valid && desc_ready`.
- **Completion edge detect.** `s2mm_introut` is registered once. `irq_rise = introut && !introut_q`.
- **FSM states:** IDLE, LOAD, ISSUE, WAIT, NEXT.
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD: pop the FIFO head into `cur_addr`, `remaining`, `cur_tag`.
    - If `remaining == 0`: pulse `done_valid` with `done_err=1` and go to IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: set `chunk = min(remaining, MAX_CHUNK)`. Drive `dest_addr=cur_addr`, `byte_num=chunk`, `start=1` for exactly one cycle. Go to WAIT.
  - WAIT: hold `dest_addr` and `byte_num` stable, because the write controller samples `byte_num` continuously. On `irq_rise`, go to NEXT.
  - NEXT: `cur_addr += chunk` (64-bit, wraps modulo 2^64, no error); `remaining -= chunk`.
    - If `remaining == 0`: pulse `done_valid` with `done_err=0`, `done_tag=cur_tag`, and go to IDLE.
    - Otherwise go to ISSUE.
- **Spurious edges.** An `irq_rise` seen outside WAIT is ignored.
- **Width rules.**
  - `chunk`, `remaining` and `byte_num` are 32 bits.
  - `MAX_CHUNK` is compared unsigned.
  - `remaining` never underflows, because `chunk ≤ remaining`.
- **Reset mid-transfer.** The FIFO is flushed, the FSM returns to IDLE, and the in-flight chunk is abandoned with no `done_valid`. Software must reset the DMA core separately.

## Timing
- **Reset values.** `desc_ready=1`, `start=0`, `dest_addr=0`, `byte_num=0`, `busy=0`, `done_valid=0`, `done_tag=0`, `done_err=0`. All outputs are registered.
- **`desc_ready`.** Equals `!full` and is registered. A pop in the same cycle does not raise `desc_ready` until the next cycle. A push and pop in the same cycle while non-empty and not full leaves the count unchanged.
- **Issue latency.** A descriptor handshaken at cycle N into an empty, idle block gives `start` high at cycle N+3 (IDLE at N+1, LOAD at N+2, ISSUE at N+3).
- **Re-issue latency.** A chunk's `irq_rise` detected at cycle M gives NEXT at M+1 and the next `start` at M+2. `done_valid` is at M+1 if this was the last chunk.
- **Back-to-back descriptors.** A queued descriptor reaches LOAD two cycles after the previous `done_valid`.
- **Simultaneous events.** `irq_rise` and `done_valid` never overlap with `start`. Enqueue is independent of FSM state.

## Configuration
- **`S2MM_DESC_TIMEOUT_EN` defined:**
  - A 32-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES`, the block pulses `done_valid` with `done_err=1`, discards the remaining chunks, and goes to IDLE.
  - `irq_rise` on the same cycle as expiry wins: normal completion.
- **Not defined:** WAIT waits indefinitely. The counter and `TIMEOUT_CYCLES` logic are absent.

## Structure
- **Package `s2mm_desc_pkg`:**
  - state enum `s2mm_desc_state_t`;
  - struct `s2mm_desc_t` (addr[63:0], len[31:0], tag[3:0]);
  - constant `S2MM_MAX_CHUNK_DFLT = 32'h0080_0000`.
- **Sub-module `s2mm_desc_fifo`:** synchronous FIFO of `s2mm_desc_t`, `DEPTH` entries, with full/empty flags and an occupancy count.
- **Top level:** the FSM, chunk arithmetic and edge detect stay in the top.

## Test plan
- **Single descriptor.** Push addr=64'h1_0000_1000, len=4096, tag=3 → one `start` at N+3 with `byte_num`=4096. After `introut` rises: `done_valid`, `done_tag`=3, `done_err`=0.
- **Split descriptor.** `MAX_CHUNK`=32'h100, push addr=0, len=32'h250 → starts at addr 0/0x100, 0x100/0x100, 0x200/0x50. A single `done_valid` after the third interrupt.
- **FIFO full.** Push 9 descriptors with `DEPTH`=8 while stalled in WAIT → `desc_ready` low after the 8th. Completing one raises `desc_ready` one cycle after the pop.
- **Zero length.** Push len=0, tag=7 → no `start`; `done_valid` with `done_err=1`, `done_tag`=7.
- **Address wrap.** Push addr=64'hFFFF_FFFF_FFFF_FF80 with len 0x100 and `MAX_CHUNK`=0x80 → second chunk addr=0. Also assert `rst` low in WAIT → all outputs return to reset values and no `done_valid` is produced.
- **Timeout, `S2MM_DESC_TIMEOUT_EN` defined.** `TIMEOUT_CYCLES`=16, no interrupt → `done_err=1` sixteen cycles after WAIT is entered.
